// File: rtl/inta_sequencer_pkg.sv
// Shared constants and FSM encoding for the interrupt-acknowledge sequencer.
package inta_sequencer_pkg;

  localparam int unsigned IR_COUNT = 8;
  localparam int unsigned LVL_W    = 3;

  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_t;

endpackage

// File: rtl/inta_sequencer_prio_resolver.sv
// Fixed-priority resolver: index of the lowest-numbered set bit (IR0 highest).
module prio_resolver
  import inta_sequencer_pkg::*;
(
  input  logic [IR_COUNT-1:0] req,
  output logic [LVL_W-1:0]    idx,
  output logic                valid
);

  // Scan from lowest priority upward so the highest-priority hit wins last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(IR_COUNT) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = LVL_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: priority resolution, ISR bookkeeping,
// two-pulse INTA vector delivery and EOI/AEOI handling.
module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int unsigned VEC_BASE_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            IRR,
  input  logic                  INTA_n,
  input  logic                  EOI,
  input  logic                  EOI_specific,
  input  logic [2:0]            EOI_level,
  input  logic                  AEOI,
  input  logic [VEC_BASE_W-1:0] vec_base,
  output logic                  INT,
  output logic [7:0]            ISR,
  output logic                  resetIRRbit,
  output logic [7:0]            data_out,
  output logic                  data_en
);

  state_t           state_q, state_d;
  logic             inta_q;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             spur_q, spur_d;
  logic [7:0]       isr_d;
  logic             int_d, rirr_d, den_d;
  logic [7:0]       dout_d;

  logic [LVL_W-1:0] irr_lvl, isr_lvl;
  logic             irr_vld, isr_vld;
  logic             fall_c, rise_c, int_req_c;

  prio_resolver u_irr_prio (
    .req   (IRR),
    .idx   (irr_lvl),
    .valid (irr_vld)
  );

  prio_resolver u_isr_prio (
    .req   (ISR),
    .idx   (isr_lvl),
    .valid (isr_vld)
  );

  assign fall_c    = !INTA_n &&  inta_q;
  assign rise_c    =  INTA_n && !inta_q;
  assign int_req_c = irr_vld && (!isr_vld || (irr_lvl < isr_lvl));

  // Next-state and next-output logic; EOI is applied before any ISR set.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    spur_d  = spur_q;
    isr_d   = ISR;
    rirr_d  = 1'b0;
    den_d   = 1'b0;
    int_d   = 1'b0;
    dout_d  = '0;

    if (EOI) begin
      if (EOI_specific) begin
        isr_d[EOI_level] = 1'b0;
      end else if (isr_vld) begin
        isr_d[isr_lvl] = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = ACK1;
          if (int_req_c) begin
            lvl_d          = irr_lvl;
            spur_d         = 1'b0;
            isr_d[irr_lvl] = 1'b1;
            rirr_d         = 1'b1;
          end else begin
            lvl_d  = SPURIOUS_LVL;
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (fall_c) begin
          state_d = ACK2;
          den_d   = 1'b1;
        end
      end
      ACK2: begin
        if (rise_c) begin
          state_d = IDLE;
          if (AEOI && !spur_q) begin
            isr_d[lvl_q] = 1'b0;
          end
        end else begin
          den_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    int_d  = (state_d == IDLE) && int_req_c;
    dout_d = den_d ? 8'({vec_base, lvl_d}) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      inta_q      <= 1'b1;
      lvl_q       <= '0;
      spur_q      <= 1'b0;
      ISR         <= '0;
      INT         <= 1'b0;
      resetIRRbit <= 1'b0;
      data_out    <= '0;
      data_en     <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_q      <= INTA_n;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      ISR         <= isr_d;
      INT         <= int_d;
      resetIRRbit <= rirr_d;
      data_out    <= dout_d;
      data_en     <= den_d;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: directed INTA sequences, EOI/AEOI and reset cases.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IRR;
  logic       INTA_n;
  logic       EOI;
  logic       EOI_specific;
  logic [2:0] EOI_level;
  logic       AEOI;
  logic [4:0] vec_base;
  logic       INT;
  logic [7:0] ISR;
  logic       resetIRRbit;
  logic [7:0] data_out;
  logic       data_en;

  int n_checks = 0;
  int n_pass   = 0;
  int rirr_cnt = 0;
  int r0;
  logic [7:0] exp_q[$];
  logic       den_prev  = 1'b0;
  logic       rirr_prev = 1'b0;

  inta_sequencer #(.VEC_BASE_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .IRR          (IRR),
    .INTA_n       (INTA_n),
    .EOI          (EOI),
    .EOI_specific (EOI_specific),
    .EOI_level    (EOI_level),
    .AEOI         (AEOI),
    .vec_base     (vec_base),
    .INT          (INT),
    .ISR          (ISR),
    .resetIRRbit  (resetIRRbit),
    .data_out     (data_out),
    .data_en      (data_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic inta_pulse(input bit eoi_first);
    INTA_n = 1'b0;
    if (eoi_first) begin
      EOI = 1'b1;
      EOI_specific = 1'b0;
    end
    tick(1);
    EOI = 1'b0;
    tick(1);
    INTA_n = 1'b1;
    tick(2);
  endtask

  task automatic do_eoi(input bit spec, input logic [2:0] lvl);
    EOI = 1'b1;
    EOI_specific = spec;
    EOI_level = lvl;
    tick(1);
    EOI = 1'b0;
    tick(1);
  endtask

  // Full two-pulse acknowledge; IRR is cleared between pulses as the IRR block would.
  task automatic ack_seq(input logic [7:0] vec);
    exp_q.push_back(vec);
    inta_pulse(1'b0);
    IRR = 8'h00;
    inta_pulse(1'b0);
  endtask

  // Monitor: pops the scoreboard on each new vector and counts resetIRRbit pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (data_en && !den_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_vector: got 0x%0h with data_en, expected none", data_out);
        end else begin
          chk("vector", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      if (!data_en && data_out !== 8'h00) begin
        n_checks++;
        $display("FAIL data_out_idle: got 0x%0h, expected 0x0", data_out);
      end
      if (resetIRRbit && !rirr_prev) rirr_cnt++;
      den_prev  = data_en;
      rirr_prev = resetIRRbit;
    end
  end

  initial begin
    reset = 1'b1; IRR = 8'h00; INTA_n = 1'b1; EOI = 1'b0; EOI_specific = 1'b0;
    EOI_level = 3'd0; AEOI = 1'b0; vec_base = 5'h08;
    tick(3);
    @(negedge clk);
    chk("rst_INT", 32'(INT), 32'd0);
    chk("rst_ISR", 32'(ISR), 32'h00);
    chk("rst_rirr", 32'(resetIRRbit), 32'd0);
    chk("rst_data_en", 32'(data_en), 32'd0);
    reset = 1'b0;
    tick(1);

    // Basic acknowledge of IR2
    IRR = 8'h04;
    tick(2); @(negedge clk);
    chk("ir2_INT", 32'(INT), 32'd1);
    r0 = rirr_cnt;
    ack_seq(8'h42);
    @(negedge clk);
    chk("ir2_ISR", 32'(ISR), 32'h04);
    chk("ir2_rirr_pulses", 32'(rirr_cnt - r0), 32'd1);
    chk("ir2_rirr_low", 32'(resetIRRbit), 32'd0);

    // Priority versus in-service level
    IRR = 8'h10;
    tick(2); @(negedge clk);
    chk("lower_prio_INT", 32'(INT), 32'd0);
    IRR = 8'h01;
    tick(2); @(negedge clk);
    chk("higher_prio_INT", 32'(INT), 32'd1);
    IRR = 8'h00;
    do_eoi(1'b1, 3'd2);
    @(negedge clk);
    chk("spec_eoi2_ISR", 32'(ISR), 32'h00);

    // Spurious: request withdrawn before first INTA
    IRR = 8'h04;
    tick(2); @(negedge clk);
    chk("spur_INT", 32'(INT), 32'd1);
    IRR = 8'h00;
    tick(1);
    r0 = rirr_cnt;
    ack_seq(8'h47);
    @(negedge clk);
    chk("spur_ISR", 32'(ISR), 32'h00);
    chk("spur_rirr_pulses", 32'(rirr_cnt - r0), 32'd0);

    // AEOI with IRR changing mid-sequence (latched level must hold)
    AEOI = 1'b1;
    IRR = 8'h08;
    tick(2);
    exp_q.push_back(8'h43);
    inta_pulse(1'b0);
    IRR = 8'h01;
    tick(1); @(negedge clk);
    chk("ack1_INT_held_low", 32'(INT), 32'd0);
    chk("aeoi_mid_ISR", 32'(ISR), 32'h08);
    tick(1);
    inta_pulse(1'b0);
    @(negedge clk);
    chk("aeoi_ISR", 32'(ISR), 32'h00);
    chk("aeoi_reeval_INT", 32'(INT), 32'd1);
    IRR = 8'h00;
    tick(2);

    // No AEOI: ISR[3] held until EOI
    AEOI = 1'b0;
    IRR = 8'h08;
    tick(2);
    ack_seq(8'h43);
    @(negedge clk);
    chk("no_aeoi_ISR", 32'(ISR), 32'h08);

    // Nest IR1 on top, then EOIs
    IRR = 8'h02;
    tick(2); @(negedge clk);
    chk("nest_INT", 32'(INT), 32'd1);
    ack_seq(8'h41);
    @(negedge clk);
    chk("nest_ISR", 32'(ISR), 32'h0A);
    do_eoi(1'b0, 3'd0);
    @(negedge clk);
    chk("nonspec_eoi_ISR", 32'(ISR), 32'h08);
    do_eoi(1'b1, 3'd3);
    @(negedge clk);
    chk("spec_eoi3_ISR", 32'(ISR), 32'h00);
    do_eoi(1'b0, 3'd0);
    @(negedge clk);
    chk("nonspec_eoi_empty_ISR", 32'(ISR), 32'h00);

    // EOI coinciding with the ISR set: EOI first, new bit survives
    IRR = 8'h08;
    tick(2);
    ack_seq(8'h43);
    IRR = 8'h02;
    tick(2);
    exp_q.push_back(8'h41);
    inta_pulse(1'b1);
    IRR = 8'h00;
    inta_pulse(1'b0);
    @(negedge clk);
    chk("eoi_coincide_ISR", 32'(ISR), 32'h02);
    do_eoi(1'b1, 3'd1);
    @(negedge clk);
    chk("eoi_coincide_clear_ISR", 32'(ISR), 32'h00);

    // Reset while driving the vector in ACK2
    IRR = 8'h04;
    tick(2);
    exp_q.push_back(8'h42);
    inta_pulse(1'b0);
    IRR = 8'h00;
    INTA_n = 1'b0;
    tick(2); @(negedge clk);
    chk("ack2_data_en", 32'(data_en), 32'd1);
    reset = 1'b1;
    INTA_n = 1'b1;
    tick(1); @(negedge clk);
    chk("midrst_data_en", 32'(data_en), 32'd0);
    chk("midrst_ISR", 32'(ISR), 32'h00);
    chk("midrst_INT", 32'(INT), 32'd0);
    reset = 1'b0;
    tick(6); @(negedge clk);
    chk("post_rst_data_en", 32'(data_en), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
